// File: rtl/spi_sram_arbiter_if.sv
// spi_sram_arbiter_if: two requester ports plus the SPI SRAM master request/read-data bus
interface spi_sram_arbiter_if;
  logic [23:0] p0_addr, p1_addr, mem_addr;
  logic        p0_en, p1_en, p0_wr, p1_wr;
  logic        p0_rburst, p1_rburst, p0_wburst, p1_wburst;
  logic [7:0]  p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata0;
  logic        p0_rdy, p1_rdy, p0_rvalid, p1_rvalid;
  logic        mem_wr, mem_rburst, mem_wburst, mem_en, mem_rdy, mem_rdata_load;
  modport slave (
    input  p0_addr, p0_en, p0_wr, p0_rburst, p0_wburst, p0_wdata,
    input  p1_addr, p1_en, p1_wr, p1_rburst, p1_wburst, p1_wdata,
    input  mem_rdy, mem_rdata_load, mem_rdata0,
    output p0_rdy, p0_rvalid, p0_rdata, p1_rdy, p1_rvalid, p1_rdata,
    output mem_addr, mem_wr, mem_wdata, mem_rburst, mem_wburst, mem_en
  );
  modport master (
    output p0_addr, p0_en, p0_wr, p0_rburst, p0_wburst, p0_wdata,
    output p1_addr, p1_en, p1_wr, p1_rburst, p1_wburst, p1_wdata,
    output mem_rdy, mem_rdata_load, mem_rdata0,
    input  p0_rdy, p0_rvalid, p0_rdata, p1_rdy, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wr, mem_wdata, mem_rburst, mem_wburst, mem_en
  );
endinterface

// File: rtl/spi_sram_arbiter.sv
// spi_sram_arbiter: round-robin two-port arbiter in front of an SPI SRAM master; define SPI_SRAM_ARB_BURST_LIMIT_EN to cap bursts at MAX_BURST beats
module spi_sram_arbiter #(
  parameter int MAX_BURST = 16
) (
  input logic clk,
  input logic rst,
  spi_sram_arbiter_if.slave io_bus
);
  typedef enum logic {ARB, OWN} state_t;
  state_t      r_state;
  logic        r_g, r_last, r_rd_owner, r_rd_seen;
  logic        w_own, w_en, w_wr, w_rburst, w_wburst, w_capped, w_acc, w_burst, w_win;
  logic [23:0] w_addr;
  logic [7:0]  w_wdata;
  // Select the owner's request; outputs are forced quiet whenever no owner exists or reset is held
  always_comb begin
    w_own    = (r_state == OWN) & ~rst;
    w_en     = r_g ? io_bus.p1_en     : io_bus.p0_en;
    w_wr     = r_g ? io_bus.p1_wr     : io_bus.p0_wr;
    w_rburst = r_g ? io_bus.p1_rburst : io_bus.p0_rburst;
    w_wburst = r_g ? io_bus.p1_wburst : io_bus.p0_wburst;
    w_addr   = r_g ? io_bus.p1_addr   : io_bus.p0_addr;
    w_wdata  = r_g ? io_bus.p1_wdata  : io_bus.p0_wdata;
    w_acc    = w_own & w_en & io_bus.mem_rdy;
    w_burst  = w_wr ? (w_wburst & ~w_capped) : (w_rburst & ~w_capped);
    w_win    = (io_bus.p0_en & io_bus.p1_en) ? ~r_last : io_bus.p1_en;
  end
  assign io_bus.mem_en     = w_own & w_en;
  assign io_bus.mem_wr     = w_own & w_wr;
  assign io_bus.mem_addr   = w_own ? w_addr : 24'h0;
  assign io_bus.mem_wdata  = w_own ? w_wdata : 8'h0;
  assign io_bus.mem_rburst = w_own & w_rburst & ~w_capped;
  assign io_bus.mem_wburst = w_own & w_wburst & ~w_capped;
  assign io_bus.p0_rdy     = w_own & ~r_g & io_bus.mem_rdy & io_bus.p0_en;
  assign io_bus.p1_rdy     = w_own & r_g & io_bus.mem_rdy & io_bus.p1_en;
  assign io_bus.p0_rvalid  = ~rst & io_bus.mem_rdata_load & r_rd_seen & ~r_rd_owner;
  assign io_bus.p1_rvalid  = ~rst & io_bus.mem_rdata_load & r_rd_seen & r_rd_owner;
  assign io_bus.p0_rdata   = io_bus.mem_rdata0;
  assign io_bus.p1_rdata   = io_bus.mem_rdata0;
`ifdef SPI_SRAM_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] r_cnt;
  // Count accepted beats of the current ownership, saturating; idle ARB cycles restart it
  always_ff @(posedge clk)
    if (rst || r_state == ARB) r_cnt <= '0;
    else if (w_acc && !(&r_cnt)) r_cnt <= r_cnt + CW'(1);
  assign w_capped = r_cnt >= CW'(MAX_BURST - 1);
`else
  assign w_capped = 1'b0 & (MAX_BURST > 0);
`endif
  // Ownership FSM: grant in ARB, release on a non-burst accept or when the owner withdraws
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ARB;
      r_g     <= 1'b0;
      r_last  <= 1'b1;
    end else if (r_state == ARB) begin
      if (io_bus.p0_en | io_bus.p1_en) begin
        r_state <= OWN;
        r_g     <= w_win;
        r_last  <= w_win;
      end
    end else if (w_acc ? !w_burst : !w_en) r_state <= ARB;
  // Remember who issued the latest accepted read so returning bytes are routed to it
  always_ff @(posedge clk)
    if (rst) begin
      r_rd_owner <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else if (w_acc && !w_wr) begin
      r_rd_owner <= r_g;
      r_rd_seen  <= 1'b1;
    end
endmodule

// File: tb/tb_spi_sram_arbiter.sv
// tb_spi_sram_arbiter: scoreboard bench with a cycle-level reference model of grant, forwarding and read routing
module tb_spi_sram_arbiter;
`ifdef SPI_SRAM_ARB_BURST_LIMIT_EN
  localparam int MB = 4;
  localparam bit LIMIT = 1'b1;
`else
  localparam int MB = 16;
  localparam bit LIMIT = 1'b0;
`endif
  typedef struct packed {logic [23:0] a; logic wr; logic [7:0] d; logic b;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_sram_arbiter_if bus();
  spi_sram_arbiter #(.MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .io_bus(bus));
  beat_t q0[$], q1[$];
  int grants[$];
  int checks = 0, failures = 0;
  bit rnd_mem = 1'b0;
  bit m_arb = 1'b1, m_owner = 1'b0, m_last = 1'b1, m_rd_owner = 1'b0, m_rd_seen = 1'b0;
  int m_beats = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit n, input bit en, input beat_t x);
    if (n) begin
      bus.p1_en = en; bus.p1_addr = x.a; bus.p1_wr = x.wr; bus.p1_wdata = x.d;
      bus.p1_wburst = x.wr & x.b; bus.p1_rburst = !x.wr & x.b;
    end else begin
      bus.p0_en = en; bus.p0_addr = x.a; bus.p0_wr = x.wr; bus.p0_wdata = x.d;
      bus.p0_wburst = x.wr & x.b; bus.p0_rburst = !x.wr & x.b;
    end
  endtask

  task automatic req(input bit n, input int beats, input bit wr, input logic [23:0] addr);
    for (int i = 0; i < beats; i++) begin
      beat_t x;
      int t;
      x.a = addr + 24'(i);
      x.wr = wr;
      x.d = wr ? 8'($urandom) : 8'h00;
      x.b = (i < beats - 1);
      if (n) q1.push_back(x); else q0.push_back(x);
      drive(n, 1'b1, x);
      t = 0;
      do begin @(negedge clk); t++; end while (!(n ? bus.p1_rdy : bus.p0_rdy) && t < 200);
      chk("req_rdy", 32'(n ? bus.p1_rdy : bus.p0_rdy), 32'(1));
      @(posedge clk); #1;
    end
    drive(n, 1'b0, '0);
  endtask

  task automatic check_order(input string nm, input int n, input logic [15:0] seq);
    chk({nm, "_len"}, 32'(grants.size()), 32'(n));
    for (int i = 0; i < n && i < grants.size(); i++) chk(nm, 32'(grants[i]), 32'(seq[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_mem) begin
        bus.mem_rdy = $urandom_range(0, 3) != 0;
        bus.mem_rdata_load = $urandom_range(0, 2) == 0;
        bus.mem_rdata0 = 8'($urandom);
      end
    end
  end

  initial begin
    forever begin
      bit o_en, acc, rd_acc, capped;
      beat_t e;
      @(negedge clk);
      if (rst) begin
        chk("rst_quiet", 32'({bus.mem_en, bus.p0_rdy, bus.p1_rdy, bus.p0_rvalid, bus.p1_rvalid}), 32'(0));
        chk("rst_mem_data", 32'({bus.mem_addr, bus.mem_wdata}), 32'(0));
        m_arb = 1'b1; m_last = 1'b1; m_owner = 1'b0; m_rd_seen = 1'b0; m_rd_owner = 1'b0;
        q0.delete(); q1.delete();
      end else begin
        rd_acc = 1'b0;
        chk("rvalid", 32'({bus.p1_rvalid, bus.p0_rvalid}),
            32'({bus.mem_rdata_load & m_rd_seen & m_rd_owner, bus.mem_rdata_load & m_rd_seen & !m_rd_owner}));
        chk("rdata", 32'({bus.p1_rdata, bus.p0_rdata}), 32'({2{bus.mem_rdata0}}));
        if (m_arb) begin
          chk("arb_idle", 32'({bus.mem_en, bus.p0_rdy, bus.p1_rdy}), 32'(0));
          chk("arb_data", 32'({bus.mem_addr, bus.mem_wr, bus.mem_rburst, bus.mem_wburst}), 32'(0));
          if (bus.p0_en | bus.p1_en) begin
            m_owner = (bus.p0_en & bus.p1_en) ? !m_last : bus.p1_en;
            m_last = m_owner;
            m_arb = 1'b0;
            m_beats = 0;
          end
        end else begin
          o_en = m_owner ? bus.p1_en : bus.p0_en;
          acc = o_en & bus.mem_rdy;
          chk("own_mem_en", 32'(bus.mem_en), 32'(o_en));
          chk("own_rdy", 32'({bus.p1_rdy, bus.p0_rdy}), m_owner ? 32'({acc, 1'b0}) : 32'({1'b0, acc}));
          if (acc) begin
            grants.push_back(int'(m_owner));
            chk("sb_nonempty", 32'((m_owner ? q1.size() : q0.size()) > 0), 32'(1));
            e = '0;
            if (m_owner && q1.size() > 0) e = q1.pop_front();
            else if (!m_owner && q0.size() > 0) e = q0.pop_front();
            capped = LIMIT && m_beats >= MB - 1;
            m_beats++;
            chk("fwd_addr", 32'(bus.mem_addr), 32'(e.a));
            chk("fwd_wr_data", 32'({bus.mem_wr, bus.mem_wdata}), 32'({e.wr, e.d}));
            chk("fwd_burst", 32'({bus.mem_wburst, bus.mem_rburst}),
                e.wr ? 32'({e.b & !capped, 1'b0}) : 32'({1'b0, e.b & !capped}));
            if (!(e.b && !capped)) m_arb = 1'b1;
            if (!e.wr) rd_acc = 1'b1;
          end else if (!o_en) m_arb = 1'b1;
        end
        if (rd_acc) begin
          m_rd_owner = m_owner;
          m_rd_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    beat_t x;
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    bus.mem_rdy = 1'b0; bus.mem_rdata_load = 1'b0; bus.mem_rdata0 = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    grants.delete();
    fork
      req(1'b0, 1, 1'b0, 24'h000010);
      begin repeat (3) @(posedge clk); #1 bus.mem_rdy = 1'b1; end
    join
    bus.mem_rdata_load = 1'b1; bus.mem_rdata0 = 8'hA5;
    @(negedge clk);
    chk("single_rvalid", 32'({bus.p1_rvalid, bus.p0_rvalid}), 32'(2'b01));
    chk("single_rdata", 32'(bus.p0_rdata), 32'(8'hA5));
    @(posedge clk); #1 bus.mem_rdata_load = 1'b0;
    check_order("order_single", 1, 16'h0);
    do_reset();
    grants.delete();
    fork req(1'b0, 1, 1'b0, 24'h000100); req(1'b1, 1, 1'b1, 24'h000200); join
    fork req(1'b0, 1, 1'b1, 24'h000300); req(1'b1, 1, 1'b0, 24'h000400); join
    check_order("order_tie", 4, 16'b1010);
    grants.delete();
    fork
      req(1'b1, 4, 1'b1, 24'h000500);
      begin @(posedge clk); #1 req(1'b0, 1, 1'b0, 24'h000600); end
    join
    check_order("order_wburst", 5, 16'b01111);
`ifdef SPI_SRAM_ARB_BURST_LIMIT_EN
    grants.delete();
    fork
      req(1'b0, 6, 1'b0, 24'h000700);
      begin @(posedge clk); #1 req(1'b1, 1, 1'b0, 24'h000800); end
    join
    check_order("order_cap", 7, 16'b0010000);
`endif
    rnd_mem = 1'b1;
    fork
      begin
        repeat (25) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          req(1'b0, int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 24'($urandom));
        end
      end
      begin
        repeat (25) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          req(1'b1, int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 24'($urandom));
        end
      end
    join
    rnd_mem = 1'b0;
    @(posedge clk); #1;
    chk("sb_drain", 32'(q0.size() + q1.size()), 32'(0));
    bus.mem_rdy = 1'b1; bus.mem_rdata_load = 1'b0;
    x = {24'h000900, 1'b0, 8'h00, 1'b1};
    q0.push_back(x); q0.push_back(x);
    drive(1'b0, 1'b1, x);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; bus.mem_rdata_load = 1'b1;
    @(negedge clk);
    chk("midburst_rst", 32'({bus.mem_en, bus.p0_rdy, bus.p0_rvalid, bus.p1_rvalid}), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_rdata_load = 1'b0;
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("post_rst_idle", 32'({bus.mem_en, bus.p0_rdy, bus.p1_rdy}), 32'(0));
    @(posedge clk); #1;
    grants.delete();
    req(1'b1, 1, 1'b0, 24'h000A00);
    check_order("order_post_rst", 1, 16'h1);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_sram_arbiter.md
SPI_SRAM_ARBITER -- requirements
Module: spi_sram_arbiter

Interface
REQ-001 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter MAX_BURST, default 16, accepted beats per ownership when the burst limit is compiled in.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pN_addr  in  24  byte address; N=0,1, and the same applies to every pN_* line below.
REQ-006 pN_en  in  1  request valid; held until pN_rdy.
REQ-007 pN_wr  in  1  1 = write, 0 = read.
REQ-008 pN_rburst / pN_wburst  in  1 each  continue read/write burst.
REQ-009 pN_wdata  in  8  write byte.
REQ-010 pN_rdy  out  1  request accepted this cycle.
REQ-011 pN_rvalid  out  1  read byte valid this cycle.
REQ-012 pN_rdata  out  8  read byte; equals mem_rdata0 unconditionally.
REQ-013 mem_addr / mem_wr / mem_wdata / mem_rburst / mem_wburst / mem_en  out  24/1/8/1/1/1  request forwarded to the SPI SRAM master.
REQ-014 mem_rdy  in  1  master accepts when mem_en and mem_rdy are both high.
REQ-015 mem_rdata_load  in  1  master read byte strobe.
REQ-016 mem_rdata0  in  8  master read byte.

Function
REQ-017 States: ARB (no owner) and OWN (owner = grant register g).
- In ARB, any pN_en moves to OWN next cycle, so arbitration latency is 1 cycle.
- Single requester wins.
- If both request, the port != last_grant wins (round-robin).
- Both g and last_grant update to the winner.
REQ-018 In ARB, mem_en = 0, all pN_rdy = 0, and the mem_* data outputs are 0.
REQ-019 In OWN, mem_* mirror the owner's signals combinationally; p[g]_rdy = mem_rdy & p[g]_en; the other port's rdy = 0.
REQ-020 Accept = OWN & mem_en & mem_rdy.
- Effective burst = (owner wr ? wburst : rburst) & ~capped.
- Accept with effective burst 0 moves to ARB next cycle.
- Accept with effective burst 1 stays in OWN.
REQ-021 In OWN with p[g]_en = 0 and no accept this cycle, the block moves to ARB next cycle (abandon).
REQ-022 Beat counter: cleared on entering OWN, incremented per accept, saturating; width = clog2(MAX_BURST+1).
REQ-023 Read tracking:
- On an accepted read, rd_owner <= g.
- pN_rvalid = mem_rdata_load & (rd_owner == N) & rd_seen.
- rd_seen is set by the first accepted read and never cleared except by reset.
REQ-024 If mem_rdata_load and a read accept fall in the same cycle, rvalid SHALL use the pre-update rd_owner.
REQ-025 Write beats SHALL produce no rvalid.
REQ-026 The arbiter SHALL NOT buffer requests.
- Requesters hold pN_en and their payload until pN_rdy.
- Payload changes while unaccepted are forwarded as-is.

Reset
REQ-027 While rst = 1 (sync):
- state = ARB, last_grant = 1 (so port 0 wins the first tie), g = 0.
- Beat counter = 0, rd_owner = 0, rd_seen = 0.
REQ-028 Output values in reset: mem_en = 0, all mem_* = 0, pN_rdy = 0, pN_rvalid = 0.
REQ-029 Reset mid-burst SHALL drop ownership immediately; the SPI SRAM master SHALL share the same rst.

Configuration
REQ-030 Macro SPI_SRAM_ARB_BURST_LIMIT_EN controls the burst limit.
- Defined: capped = (beat count >= MAX_BURST - 1) at accept, and the forwarded mem_rburst/mem_wburst are forced to 0 while capped. A burst is therefore cut after MAX_BURST beats and ownership passes to the other port.
- Undefined: capped = 0, the beat counter is absent, and bursts are unlimited.

Verification
REQ-031 Reset, then p0 read 0x000010 alone: mem_en rises 1 cycle after p0_en; on mem_rdy, p0_rdy pulses; p0_rvalid accompanies mem_rdata_load with p0_rdata = mem_rdata0 = 0xA5; p1_rvalid stays 0.
REQ-032 p0 and p1 request in the same cycle after reset: p0 is granted first; p1 is granted in the ARB cycle after p0's accept; the next simultaneous tie goes to p0 again (alternation).
REQ-033 p1 write burst with wburst held across 4 beats (MAX_BURST = 16) while p0 requests: p1 keeps ownership for all 4 accepts; p0_rdy stays 0 until p1 drops wburst and its final accept completes.
REQ-034 With SPI_SRAM_ARB_BURST_LIMIT_EN and MAX_BURST = 4, p0 rburst held continuously: mem_rburst is forced to 0 at the 4th accept; ARB follows; a pending p1 is granted.
REQ-035 Assert rst mid-read-burst: the next cycle shows mem_en = 0, pN_rdy = 0, pN_rvalid = 0; after release, p1 alone is granted in 1 cycle.
